nios2_qsys_oci_dct_unpacker: RTL and testbench
==============================================

Name: nios2_qsys_oci_dct_unpacker

Overview:
- Consumer end of the OCI direct-compressed-trace (DCT) packing path.
- The packer shifts 2-bit DCT codes into a 30-bit buffer, newest code in bits [1:0], and reports the number of valid codes as a 4-bit count.
- This block accepts one packed buffer/count pair per handshake and replays its codes oldest-first, one code per cycle, on a valid/ready stream.
- It feeds the trace decode/debug path and keeps status counters.

Parameters:
- CODE_W, 2, bits per DCT code.
- DEPTH, 15, maximum codes per packed buffer.
- BUF_W, 30, packed buffer width (must equal CODE_W*DEPTH).
- COUNT_W, 4, width of the count field.
- STAT_W, 16, width of the status counters.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  packed buffer offered.
- in_ready  out  1  block can accept a packed buffer this cycle.
- in_buffer  in  BUF_W  packed codes; newest in [1:0].
- in_count  in  COUNT_W  number of valid codes in in_buffer.
- out_valid  out  1  out_code valid.
- out_ready  in  1  downstream accepts out_code.
- out_code  out  CODE_W  current DCT code.
- out_last  out  1  current code is the final code of its buffer.
- empty_drop  out  1  one-cycle pulse: a buffer with count 0 was accepted and discarded.
- count_err  out  1  one-cycle pulse: an accepted count exceeded DEPTH and was clamped.
- frames_done  out  STAT_W  number of buffers fully emitted; wraps.
- codes_total  out  STAT_W  number of codes emitted; wraps.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state=IDLE; shift register=0; remaining=0.
  - out_valid=0, out_last=0, out_code=0.
  - empty_drop=0, count_err=0.
  - frames_done=0, codes_total=0.
  - Reset mid-frame discards all pending codes. No partial output follows reset.
- State IDLE: in_ready=1, out_valid=0.
- State EMIT:
  - out_valid=1; out_code=sh[BUF_W-1 -: CODE_W]; out_last=(remaining==1).
  - in_ready = out_ready & out_last. This is combinational, so back-to-back frames need no bubble.
- Accept (in_valid & in_ready), with n = min(in_count, DEPTH):
  - If in_count > DEPTH: count_err pulses for the next cycle.
  - If n==0: no codes are emitted, empty_drop pulses next cycle, state becomes IDLE.
  - If n>0: sh <= in_buffer << (CODE_W*(DEPTH-n)), which left-aligns the oldest code at the MSBs. remaining <= n. State becomes EMIT.
  - First code appears on out_code the cycle after acceptance (latency 1).
- Output handshake (out_valid & out_ready):
  - sh <<= CODE_W; remaining decrements; codes_total increments.
  - If out_last: frames_done increments.
  - If out_last and a simultaneous accept occurs: the accept rules above apply in the same edge, giving a seamless switch to the new frame, or IDLE if it has count 0.
  - If out_last and no accept: state becomes IDLE.
- Back-pressure: with out_valid=1 and out_ready=0, out_code, out_last and all state hold. in_ready=0 unless the held beat is last and out_ready=1.
- Bits of in_buffer above CODE_W*n are ignored.
- Counters wrap modulo 2^STAT_W with no saturation.
- Status pulses are registered, one cycle wide. A count_err and an empty_drop can both occur only when DEPTH=0, which is disallowed.

Decomposition:
- Shared package: CODE_W, DEPTH, BUF_W, COUNT_W, STAT_W; state enum {IDLE, EMIT}; DCT code values as named constants.
- Sub-module: nios2_qsys_oci_dct_stat_counter, a STAT_W wrapping counter with increment enable. It is instantiated twice, for frames_done and codes_total.
- Shift/align and FSM stay in the top module.

Test Plan:
- Basic frame:
  - Stimulus: in_buffer=30'h1B, in_count=3, out_ready=1.
  - Required: codes 1,2,3 on consecutive cycles starting 1 cycle after accept; out_last only on 3; frames_done=1, codes_total=3.
- Back-to-back:
  - Stimulus: frame A (count 2, 30'h6 → codes 1,2) then frame B (count 1, 30'h3 → code 3) held valid.
  - Required: B accepted on A's last beat; output 1,2,3 with no bubble; frames_done=2.
- Back-pressure:
  - Stimulus: count 15, all codes 2'b10 (30'h2AAAAAAA); out_ready toggles 1,0,0,1,...
  - Required: exactly 15 beats of code 2; out_code stable while stalled; in_ready=0 until last beat accepted.
- Empty and clamp:
  - Stimulus: in_count=0.
  - Required: no out_valid, empty_drop pulses once, in_ready stays 1.
  - Variant: build with DEPTH=7/BUF_W=14, send in_count=9 → count_err pulses, exactly 7 codes emitted.
- Reset mid-frame:
  - Stimulus: assert reset after 4 of 10 codes emitted.
  - Required: out_valid drops asynchronously; counters read 0; next frame (count 2, 30'h9 → codes 2,1) emits correctly.
- Counter wrap:
  - Stimulus: preload via 65536 single-code frames.
  - Required: frames_done and codes_total wrap to 0, then read 1 after the next frame.

Source files
------------

// File: rtl/nios2_qsys_oci_dct_unpacker_pkg.sv
// Shared constants and types for the OCI DCT unpacker slice.
// Holds code/buffer geometry, FSM state type and named DCT code values.
package nios2_qsys_oci_dct_unpacker_pkg;

    localparam int CODE_W  = 2;
    localparam int DEPTH   = 15;
    localparam int BUF_W   = CODE_W * DEPTH;
    localparam int COUNT_W = 4;
    localparam int STAT_W  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [CODE_W-1:0] DCT_CODE_0 = 2'd0;
    localparam logic [CODE_W-1:0] DCT_CODE_1 = 2'd1;
    localparam logic [CODE_W-1:0] DCT_CODE_2 = 2'd2;
    localparam logic [CODE_W-1:0] DCT_CODE_3 = 2'd3;

endpackage

// File: rtl/nios2_qsys_oci_dct_unpacker_if.sv
// Packed-buffer input stream, code output stream and status for the unpacker.
// slave: unpacker side (in_*, out_ready in; out_*, status out). master: peer side.
interface nios2_qsys_oci_dct_unpacker_if #(
    parameter int CODE_W  = nios2_qsys_oci_dct_unpacker_pkg::CODE_W,
    parameter int BUF_W   = nios2_qsys_oci_dct_unpacker_pkg::BUF_W,
    parameter int COUNT_W = nios2_qsys_oci_dct_unpacker_pkg::COUNT_W,
    parameter int STAT_W  = nios2_qsys_oci_dct_unpacker_pkg::STAT_W
);

    logic               in_valid;
    logic               in_ready;
    logic [BUF_W-1:0]   in_buffer;
    logic [COUNT_W-1:0] in_count;
    logic               out_valid;
    logic               out_ready;
    logic [CODE_W-1:0]  out_code;
    logic               out_last;
    logic               empty_drop;
    logic               count_err;
    logic [STAT_W-1:0]  frames_done;
    logic [STAT_W-1:0]  codes_total;

    modport slave (
        input  in_valid, in_buffer, in_count, out_ready,
        output in_ready, out_valid, out_code, out_last,
        output empty_drop, count_err, frames_done, codes_total
    );

    modport master (
        output in_valid, in_buffer, in_count, out_ready,
        input  in_ready, out_valid, out_code, out_last,
        input  empty_drop, count_err, frames_done, codes_total
    );

endinterface

// File: rtl/nios2_qsys_oci_dct_stat_counter.sv
// Wrapping status counter with increment enable.
// Ports: clk, reset (async high), i_en increment, o_count current value.
module nios2_qsys_oci_dct_stat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/nios2_qsys_oci_dct_unpacker.sv
// Replays packed DCT codes oldest-first, one per cycle, with status counters.
// Ports: clk, reset (async high), bus (slave: packed input, code output, status).
module nios2_qsys_oci_dct_unpacker #(
    parameter int CODE_W  = nios2_qsys_oci_dct_unpacker_pkg::CODE_W,
    parameter int DEPTH   = nios2_qsys_oci_dct_unpacker_pkg::DEPTH,
    parameter int BUF_W   = CODE_W * DEPTH,
    parameter int COUNT_W = nios2_qsys_oci_dct_unpacker_pkg::COUNT_W,
    parameter int STAT_W  = nios2_qsys_oci_dct_unpacker_pkg::STAT_W
) (
    input logic clk,
    input logic reset,
    nios2_qsys_oci_dct_unpacker_if.slave bus
);

    import nios2_qsys_oci_dct_unpacker_pkg::*;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BUF_W-1:0]   r_sh;
    logic [BUF_W-1:0]   w_sh_nxt;
    logic [COUNT_W-1:0] r_rem;
    logic [COUNT_W-1:0] w_rem_nxt;
    logic               r_empty_drop;
    logic               r_count_err;
    logic               w_last;
    logic               w_accept;
    logic               w_fire;
    logic               w_over;
    logic [COUNT_W-1:0] w_n;
    logic [BUF_W-1:0]   w_aligned;

    assign w_last   = (r_state == EMIT) && (r_rem == COUNT_W'(1));
    assign w_fire   = (r_state == EMIT) && bus.out_ready;
    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_over   = bus.in_count > COUNT_W'(DEPTH);
    assign w_n      = w_over ? COUNT_W'(DEPTH) : bus.in_count;

    // Left-align so the oldest code lands in the MSBs; codes above n fall off.
    assign w_aligned = bus.in_buffer << (CODE_W * (DEPTH - int'(w_n)));

    // Ready on the last beat lets a new frame start with no bubble.
    assign bus.in_ready  = (r_state == IDLE) || (bus.out_ready && w_last);
    assign bus.out_valid = (r_state == EMIT);
    assign bus.out_code  = r_sh[BUF_W-1 -: CODE_W];
    assign bus.out_last  = w_last;
    assign bus.empty_drop = r_empty_drop;
    assign bus.count_err  = r_count_err;

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_rem_nxt   = r_rem;
        if (w_fire) begin
            w_sh_nxt  = r_sh << CODE_W;
            w_rem_nxt = r_rem - COUNT_W'(1);
            if (w_last) begin
                w_state_nxt = IDLE;
            end
        end
        // An accept on the last beat overrides the drain to IDLE.
        if (w_accept) begin
            if (w_n == '0) begin
                w_state_nxt = IDLE;
            end else begin
                w_sh_nxt    = w_aligned;
                w_rem_nxt   = w_n;
                w_state_nxt = EMIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sh         <= '0;
            r_rem        <= '0;
            r_empty_drop <= 1'b0;
            r_count_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sh         <= w_sh_nxt;
            r_rem        <= w_rem_nxt;
            r_empty_drop <= w_accept && (w_n == '0);
            r_count_err  <= w_accept && w_over;
        end
    end

    nios2_qsys_oci_dct_stat_counter #(.W(STAT_W)) u_frames (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_fire && w_last),
        .o_count (bus.frames_done)
    );

    nios2_qsys_oci_dct_stat_counter #(.W(STAT_W)) u_codes (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_fire),
        .o_count (bus.codes_total)
    );

endmodule

// File: tb/tb_nios2_qsys_oci_dct_unpacker.sv
// Randomised and directed checks of the DCT unpacker against a queue model.
// Two instances: default geometry, and DEPTH=7 for count clamping.
module tb_nios2_qsys_oci_dct_unpacker;

    typedef struct {
        logic [1:0] code;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nios2_qsys_oci_dct_unpacker_if ifa ();
    nios2_qsys_oci_dct_unpacker_if #(.BUF_W(14)) ifb ();

    nios2_qsys_oci_dct_unpacker dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    nios2_qsys_oci_dct_unpacker #(.DEPTH(7), .BUF_W(14)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int          n_checks = 0;
    int          n_err = 0;
    beat_t       q[$];
    logic [15:0] exp_frames = '0;
    logic [15:0] exp_codes = '0;
    bit          exp_drop = 0;
    int          rdy_mode = 0;
    int          rdy_phase = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        exp_frames = '0;
        exp_codes  = '0;
        exp_drop   = 0;
    endtask

    // Reference: codes pending in a queue, oldest first, one per ready cycle.
    always @(negedge clk) begin
        bit    exp_rdy;
        int    n;
        beat_t b;
        if (reset === 1'b0) begin
            exp_rdy = (q.size() == 0) || (ifa.out_ready && q[0].last);
            check("out_valid", ifa.out_valid, q.size() != 0);
            check("in_ready", ifa.in_ready, exp_rdy);
            if (q.size() != 0) begin
                check("out_code", ifa.out_code, q[0].code);
                check("out_last", ifa.out_last, q[0].last);
            end
            check("empty_drop", ifa.empty_drop, exp_drop);
            check("count_err", ifa.count_err, 0);
            check("frames_done", ifa.frames_done, exp_frames);
            check("codes_total", ifa.codes_total, exp_codes);
            exp_drop = 0;
            if (q.size() != 0 && ifa.out_ready) begin
                b = q.pop_front();
                exp_codes++;
                if (b.last) exp_frames++;
            end
            if (ifa.in_valid && exp_rdy) begin
                n = (ifa.in_count > 15) ? 15 : int'(ifa.in_count);
                if (n == 0) exp_drop = 1;
                for (int k = 0; k < n; k++) begin
                    b.code = ifa.in_buffer[2*(n-1-k) +: 2];
                    b.last = (k == n - 1);
                    q.push_back(b);
                end
            end
        end
    end

    initial begin
        ifa.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: ifa.out_ready = 1'b1;
                1: ifa.out_ready = (rdy_phase % 3 == 0);
                default: ifa.out_ready = 1'($urandom_range(0, 1));
            endcase
            rdy_phase++;
        end
    end

    task automatic send(logic [29:0] b, logic [3:0] c);
        bit ok;
        ok = 0;
        ifa.in_buffer = b;
        ifa.in_count  = c;
        ifa.in_valid  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifa.in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0 && !ifa.out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] bbuf;
        int          beats;
        int          acc;
        bit          hit;
        ifa.in_valid = 1'b0;
        ifa.in_buffer = '0;
        ifa.in_count = '0;
        ifb.in_valid = 1'b0;
        ifb.in_buffer = '0;
        ifb.in_count = '0;
        ifb.out_ready = 1'b1;

        #2;
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_out_last", ifa.out_last, 0);
        check("rst_out_code", ifa.out_code, 0);
        check("rst_empty_drop", ifa.empty_drop, 0);
        check("rst_count_err", ifa.count_err, 0);
        check("rst_frames", ifa.frames_done, 0);
        check("rst_codes", ifa.codes_total, 0);
        check("rst_in_ready", ifa.in_ready, 1);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        send(30'h1B, 4'd3);
        drain();
        check("basic_frames", ifa.frames_done, 1);
        check("basic_codes", ifa.codes_total, 3);

        send(30'h6, 4'd2);
        send(30'h3, 4'd1);
        drain();
        check("b2b_frames", ifa.frames_done, 3);
        check("b2b_codes", ifa.codes_total, 6);

        rdy_mode = 1;
        send(30'h2AAAAAAA, 4'd15);
        drain();
        rdy_mode = 0;
        check("bp_frames", ifa.frames_done, 4);
        check("bp_codes", ifa.codes_total, 21);

        send(30'($urandom), 4'd0);
        drain();
        check("empty_frames", ifa.frames_done, 4);
        check("empty_codes", ifa.codes_total, 21);

        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            send(30'($urandom), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();
        rdy_mode = 0;

        send(30'($urandom), 4'd10);
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 6) begin
                hit = 1;
                break;
            end
        end
        check("mid_reached", hit, 1);
        #1;
        reset = 1'b1;
        #1;
        check("mid_out_valid", ifa.out_valid, 0);
        check("mid_out_last", ifa.out_last, 0);
        check("mid_frames", ifa.frames_done, 0);
        check("mid_codes", ifa.codes_total, 0);
        model_clear();
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(30'h9, 4'd2);
        drain();
        check("post_rst_frames", ifa.frames_done, 1);
        check("post_rst_codes", ifa.codes_total, 2);

        bbuf = 14'($urandom);
        ifb.in_buffer = bbuf;
        ifb.in_count = 4'd9;
        ifb.in_valid = 1'b1;
        @(negedge clk);
        check("clamp_ready", ifb.in_ready, 1);
        @(posedge clk);
        #1;
        ifb.in_valid = 1'b0;
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("clamp_cerr", ifb.count_err, i == 0);
            check("clamp_drop", ifb.empty_drop, 0);
            if (ifb.out_valid) begin
                if (beats < 7) begin
                    check("clamp_code", ifb.out_code, bbuf[2*(6-beats) +: 2]);
                    check("clamp_last", ifb.out_last, beats == 6);
                end
                beats++;
            end
        end
        check("clamp_beats", beats, 7);
        check("clamp_frames", ifb.frames_done, 1);

        do_reset();
        acc = 0;
        ifa.in_count = 4'd1;
        ifa.in_valid = 1'b1;
        for (int i = 0; i < 70000 && acc < 65536; i++) begin
            ifa.in_buffer = 30'($urandom);
            @(negedge clk);
            if (ifa.in_ready) acc++;
            @(posedge clk);
            #1;
        end
        ifa.in_valid = 1'b0;
        check("wrap_accepts", acc, 65536);
        drain();
        check("wrap_frames", ifa.frames_done, 0);
        check("wrap_codes", ifa.codes_total, 0);
        send(30'($urandom), 4'd1);
        drain();
        check("wrap_frames_1", ifa.frames_done, 1);
        check("wrap_codes_1", ifa.codes_total, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
